// File: rtl/mem_router.sv
// mem_router: routes upstream memory requests to a DDR port or an MMIO device
// port (addr[28]) and returns responses upstream in request order.
// Each target may have one request in flight; a 4-deep order FIFO records
// which target owns the next upstream response, and a per-target hold
// register parks responses that complete out of order.
// Optional build macro MEM_ROUTER_DECERR_EN: addresses whose top three bits
// are not 3'b100/3'b101 go to an internal error target that answers
// 32'hDEADBEEF and never reaches either external port.
module mem_router (
   input  logic        clock,
   input  logic        reset,
   output logic        in_req_ready,
   input  logic        in_req_valid,
   input  logic        in_req_bits_is_aligned,
   input  logic [31:0] in_req_bits_addr,
   input  logic [31:0] in_req_bits_data,
   input  logic        in_req_bits_func,
   input  logic [3:0]  in_req_bits_wstrb,
   input  logic        in_resp_ready,
   output logic        in_resp_valid,
   output logic [31:0] in_resp_bits_data,
   input  logic        ddr_req_ready,
   output logic        ddr_req_valid,
   output logic        ddr_req_bits_is_aligned,
   output logic [31:0] ddr_req_bits_addr,
   output logic [31:0] ddr_req_bits_data,
   output logic        ddr_req_bits_func,
   output logic [3:0]  ddr_req_bits_wstrb,
   output logic        ddr_resp_ready,
   input  logic        ddr_resp_valid,
   input  logic [31:0] ddr_resp_bits_data,
   input  logic        dev_req_ready,
   output logic        dev_req_valid,
   output logic        dev_req_bits_is_aligned,
   output logic [31:0] dev_req_bits_addr,
   output logic [31:0] dev_req_bits_data,
   output logic        dev_req_bits_func,
   output logic [3:0]  dev_req_bits_wstrb,
   output logic        dev_resp_ready,
   input  logic        dev_resp_valid,
   input  logic [31:0] dev_resp_bits_data,
   output logic        bad_resp
);

   localparam logic [1:0] TGT_DDR = 2'd0;
   localparam logic [1:0] TGT_DEV = 2'd1;
`ifdef MEM_ROUTER_DECERR_EN
   localparam logic [1:0]  TGT_ERR  = 2'd2;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
`endif

   // slot 3 of the per-target vectors is never used; it keeps 2-bit ids in range
   logic [3:0]  busy_q, busy_d;
   logic [3:0]  held_q, held_d;
   logic [31:0] hold_data_q [4];
   logic [1:0]  order_q [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        bad_q, bad_d;

   logic [1:0]  tgt;
   logic [1:0]  head;
   logic        tgt_ready;
   logic        fifo_full;
   logic        fifo_empty;
   logic        can_issue;
   logic        accept;
   logic        pop;
   logic [3:0]  rsp_valid;
   logic [3:0]  capture;
   logic [31:0] rsp_data [4];

   // target decode from the request address
   always_comb begin
      tgt = in_req_bits_addr[28] ? TGT_DEV : TGT_DDR;
`ifdef MEM_ROUTER_DECERR_EN
      if (in_req_bits_addr[31:30] != 2'b10) begin
         tgt = TGT_ERR;
      end
`endif
   end

   // readiness of the addressed target; the error target is always ready
   always_comb begin
      case (tgt)
         TGT_DDR: tgt_ready = ddr_req_ready;
         TGT_DEV: tgt_ready = dev_req_ready;
         default: tgt_ready = 1'b1;
      endcase
   end

   assign fifo_full  = (count_q == 3'd4);
   assign fifo_empty = (count_q == 3'd0);
   assign head       = order_q[rd_ptr_q];

   // busy is the registered value, so a target freed by this cycle's pop
   // cannot be re-issued until the next cycle
   assign can_issue    = reset && !busy_q[tgt] && !fifo_full;
   assign in_req_ready = can_issue && tgt_ready;
   assign accept       = in_req_valid && in_req_ready;

   assign ddr_req_valid           = can_issue && in_req_valid && (tgt == TGT_DDR);
   assign ddr_req_bits_is_aligned = in_req_bits_is_aligned;
   assign ddr_req_bits_addr       = in_req_bits_addr;
   assign ddr_req_bits_data       = in_req_bits_data;
   assign ddr_req_bits_func       = in_req_bits_func;
   assign ddr_req_bits_wstrb      = in_req_bits_wstrb;
   assign ddr_resp_ready          = 1'b1;

   assign dev_req_valid           = can_issue && in_req_valid && (tgt == TGT_DEV);
   assign dev_req_bits_is_aligned = in_req_bits_is_aligned;
   assign dev_req_bits_addr       = in_req_bits_addr;
   assign dev_req_bits_data       = in_req_bits_data;
   assign dev_req_bits_func       = in_req_bits_func;
   assign dev_req_bits_wstrb      = in_req_bits_wstrb;
   assign dev_resp_ready          = 1'b1;

   // responses only ever come out of the hold registers, never bypassed
   assign in_resp_valid     = reset && !fifo_empty && held_q[head];
   assign in_resp_bits_data = hold_data_q[head];
   assign pop               = in_resp_valid && in_resp_ready;

   assign bad_resp = bad_q;

   // gather target responses into per-target slots
   always_comb begin
      rsp_valid[0] = ddr_resp_valid;
      rsp_data[0]  = ddr_resp_bits_data;
      rsp_valid[1] = dev_resp_valid;
      rsp_data[1]  = dev_resp_bits_data;
`ifdef MEM_ROUTER_DECERR_EN
      // the error target answers in the cycle after it is accepted
      rsp_valid[2] = busy_q[2] && !held_q[2];
      rsp_data[2]  = ERR_DATA;
`else
      rsp_valid[2] = 1'b0;
      rsp_data[2]  = 32'h0;
`endif
      rsp_valid[3] = 1'b0;
      rsp_data[3]  = 32'h0;
   end

   // a response is legal only while its target is busy and not yet holding one
   assign capture = rsp_valid & busy_q & ~held_q;

   // next-state for the tracking registers and order FIFO pointers
   always_comb begin
      busy_d   = busy_q;
      held_d   = held_q | capture;
      bad_d    = bad_q | (|(rsp_valid & ~capture));
      wr_ptr_d = wr_ptr_q + {1'b0, accept};
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      count_d  = count_q + {2'b00, accept} - {2'b00, pop};
      if (pop) begin
         busy_d[head] = 1'b0;
         held_d[head] = 1'b0;
      end
      if (accept) begin
         busy_d[tgt] = 1'b1;
      end
   end

   // control state with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         busy_q   <= '0;
         held_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bad_q    <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         held_q   <= held_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         bad_q    <= bad_d;
      end
   end

   // datapath storage; contents are qualified by held/count so no reset
   always_ff @(posedge clock) begin
      if (accept) begin
         order_q[wr_ptr_q] <= tgt;
      end
      for (int i = 0; i < 4; i++) begin
         if (capture[i]) begin
            hold_data_q[i] <= rsp_data[i];
         end
      end
   end

endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 clock  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset.
REQ-003 in_req_ready  output  1  upstream request accepted this cycle when high with in_req_valid.
REQ-004 in_req_valid / in_req_bits_is_aligned / in_req_bits_addr / in_req_bits_data / in_req_bits_func / in_req_bits_wstrb  input  1/1/32/32/1/4  upstream request bundle; func 0 = read, 1 = write.
REQ-005 in_resp_ready  input  1  upstream can take a response.
REQ-006 in_resp_valid / in_resp_bits_data  output  1/32  in-order response to upstream.
REQ-007 ddr_req_ready  input  1; ddr_req_valid / _is_aligned / _addr / _data / _func / _wstrb  output  1/1/32/32/1/4; ddr_resp_ready  output  1; ddr_resp_valid / ddr_resp_bits_data  input  1/32  DDR-model port.
REQ-008 dev_* port  same directions and widths as REQ-007  MMIO-device-model port.
REQ-009 bad_resp  output  1  sticky: a target responded with no request outstanding.

Function
REQ-010 Target decode is combinational on in_req_bits_addr: addr[28]=0 -> DDR, addr[28]=1 -> DEV.
REQ-011 Per-target state: busy (request issued, response not yet delivered upstream), held (response captured), hold_data[31:0].
REQ-012 Order FIFO: 4 entries of 2-bit target id; 2-bit pointers wrap modulo 4; count 0..4.
REQ-013 in_req_ready = !busy[t] && !fifo_full && (target t req_ready, or 1 for ERR); t = decoded target.
REQ-014 Target req_valid = in_req_valid && t matches && !busy[t] && !fifo_full; all request bits pass through unmodified, zero added latency.
REQ-015 On accept: set busy[t], push t into order FIFO; at most one request per target in flight.
REQ-016 ddr_resp_ready and dev_resp_ready are constant 1; every target resp_valid pulse is captured into hold_data and sets held in that cycle.
REQ-017 in_resp_valid = held[head]; in_resp_bits_data = hold_data[head]; head = order FIFO head entry; no same-cycle bypass (upstream latency >= 1 cycle after target response).
REQ-018 Pop when in_resp_valid && in_resp_ready: clear busy and held of head target, advance read pointer.
REQ-019 Out-of-order target completion: a response for a non-head target waits in its hold register until it reaches the head.
REQ-020 Simultaneous pop and accept to the same target: busy is evaluated as registered, so that accept is refused that cycle and admitted in the next cycle at the earliest.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 Target resp_valid while busy[target]=0 or held[target]=1: data discarded, bad_resp set to 1 and held until reset.
REQ-023 fifo_full (count=4) blocks all requests; fifo empty forces in_resp_valid=0.

Reset
REQ-024 While reset=0 at a clock edge: busy, held, pointers, count and bad_resp are cleared; hold_data is not reset.
REQ-025 During reset, in_resp_valid=0, ddr_req_valid=0, dev_req_valid=0, in_req_ready=0; in-flight transactions are abandoned; target responses arriving later set bad_resp.

Configuration
REQ-026 Macro MEM_ROUTER_DECERR_EN defined: addr[31:29] not in {3'b100, 3'b101} decodes to internal ERR target (id 2); the request is never forwarded; held[ERR] sets one cycle after accept with hold_data = 32'hDEADBEEF.
REQ-027 Macro MEM_ROUTER_DECERR_EN undefined: no ERR target; every address routes by REQ-010 only.

Verification
REQ-028 Read addr 0x80000100 with ddr_req_ready=1 and DDR response 0x12345678 two cycles later -> ddr_req_valid one cycle, in_resp_valid one cycle after the DDR response, data 0x12345678.
REQ-029 Read 0x80000000 (DDR, responds after 5 cycles), then 0xBFD003F8 (DEV, responds after 1 cycle) -> DEV data is held and both are delivered upstream in order (DDR first, then DEV) on consecutive cycles.
REQ-030 Second DDR request while the first is outstanding -> in_req_ready=0 until the first response is popped; accepted in the following cycle.
REQ-031 in_resp_ready=0 for 10 cycles with a DDR response held -> in_resp_valid stays 1 with stable data; a new DDR request is refused throughout.
REQ-032 Spurious dev_resp_valid pulse with no DEV request outstanding -> bad_resp=1 from the next cycle until reset; response stream unchanged.
REQ-033 MEM_ROUTER_DECERR_EN defined, read 0x00001000 -> no ddr/dev req_valid; in_resp_valid with data 0xDEADBEEF; reset asserted mid-flight clears in_resp_valid and leaves bad_resp=0.
